// File: rtl/core_pkg.sv
// Shared types and constants for the writeback stage: load funct3 codes,
// FSM state encoding and register-index width.
package core_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/core_wb_align.sv
// Combinational load alignment: picks the addressed byte/halfword from the raw
// memory word and sign- or zero-extends it according to funct3.
module core_wb_align
  import core_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'd0;
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'd0;
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Reserved codes (011/110/111) fall through to the full word.
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/core_wb.sv
// Writeback stage: retires execute results and aligned load data into the
// register file. Optional forwarding bus enabled by macro CORE_WB_FWD_EN.
//
// state     | meaning
// IDLE      | nothing to write, ready for the next instruction
// WAIT_LOAD | load accepted, waiting for memory data (not ready)
// WRITE     | write-port cycle for the latched result, ready for the next one
module core_wb
  import core_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ex_valid,
  output logic                 o_ex_ready,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic [31:0]          i_ex_result,
  input  logic                 i_ex_is_load,
  input  logic [2:0]           i_ex_funct3,
  input  logic [1:0]           i_ex_addr_lo,
  input  logic                 i_mem_rvalid,
  input  logic [31:0]          i_mem_rdata,
  output logic                 o_we,
  output logic [REG_IDX_W-1:0] o_waddr,
  output logic [31:0]          o_wdata,
  output logic                 o_fwd_valid,
  output logic [REG_IDX_W-1:0] o_fwd_rd,
  output logic [31:0]          o_fwd_data,
  output logic                 o_err_stray
);

  wb_state_e            r_state;
  wb_state_e            w_state_nxt;
  logic [REG_IDX_W-1:0] r_rd;
  logic [2:0]           r_funct3;
  logic [1:0]           r_addr_lo;
  logic                 r_we;
  logic [REG_IDX_W-1:0] r_waddr;
  logic [31:0]          r_wdata;
  logic                 r_err_stray;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_wr_go;
  logic [REG_IDX_W-1:0] w_wr_rd;
  logic [31:0]          w_wr_data;
  logic [31:0]          w_aligned;

  core_wb_align u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (i_mem_rdata),
    .o_data    (w_aligned)
  );

  assign w_ready  = (r_state != WAIT_LOAD);
  assign w_accept = i_ex_valid && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_go     = 1'b0;
    w_wr_rd     = r_rd;
    w_wr_data   = w_aligned;
    case (r_state)
      IDLE, WRITE: begin
        if (w_accept) begin
          if (i_ex_is_load) begin
            w_state_nxt = WAIT_LOAD;
          end else begin
            w_state_nxt = WRITE;
            w_wr_go     = 1'b1;
            w_wr_rd     = i_ex_rd;
            w_wr_data   = i_ex_result;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (i_mem_rvalid) begin
          w_state_nxt = WRITE;
          w_wr_go     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write port only moves on a real write so WADDR/WDATA hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rd        <= '0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= 32'd0;
      r_err_stray <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_wr_go && (w_wr_rd != '0);
      if (w_wr_go && (w_wr_rd != '0)) begin
        r_waddr <= w_wr_rd;
        r_wdata <= w_wr_data;
      end
      if (w_accept && i_ex_is_load) begin
        r_rd      <= i_ex_rd;
        r_funct3  <= i_ex_funct3;
        r_addr_lo <= i_ex_addr_lo;
      end
      if (i_mem_rvalid && (r_state != WAIT_LOAD)) begin
        r_err_stray <= 1'b1;
      end
    end
  end

  assign o_ex_ready  = w_ready;
  assign o_we        = r_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_err_stray = r_err_stray;

`ifdef CORE_WB_FWD_EN
  assign o_fwd_valid = r_we;
  assign o_fwd_rd    = r_waddr;
  assign o_fwd_data  = r_wdata;
`else
  assign o_fwd_valid = 1'b0;
  assign o_fwd_rd    = '0;
  assign o_fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_core_wb.sv
// Directed-vector bench for core_wb: reset, retire, load alignment,
// back-to-back, rd=0, stray data and reset-during-load scenarios.
module tb_core_wb;
  import core_pkg::*;

`ifdef CORE_WB_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        err_stray;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  core_wb dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ex_valid   (ex_valid),
    .o_ex_ready   (ex_ready),
    .i_ex_rd      (ex_rd),
    .i_ex_result  (ex_result),
    .i_ex_is_load (ex_is_load),
    .i_ex_funct3  (ex_funct3),
    .i_ex_addr_lo (ex_addr_lo),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_we         (we),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .o_fwd_valid  (fwd_valid),
    .o_fwd_rd     (fwd_rd),
    .o_fwd_data   (fwd_data),
    .o_err_stray  (err_stray)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] raw;
    logic [31:0] exp_v;
  } ld_vec_t;

  ld_vec_t lv[8];

  initial begin
    lv[0] = '{3'b100, 2'd1, 32'h0000_8000, 32'h0000_0080};
    lv[1] = '{3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
    lv[2] = '{3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001};
    lv[3] = '{3'b010, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D};
    lv[4] = '{3'b001, 2'd0, 32'hFFFF_7FFF, 32'h0000_7FFF};
    lv[5] = '{3'b011, 2'd3, 32'h8765_4321, 32'h8765_4321};
    lv[6] = '{3'b000, 2'd0, 32'hAAAA_AA7F, 32'h0000_007F};
    lv[7] = '{3'b000, 2'd2, 32'h00C3_0000, 32'hFFFF_FFC3};

    rst = 1'b1; ex_valid = 1'b0; ex_rd = '0; ex_result = '0; ex_is_load = 1'b0;
    ex_funct3 = '0; ex_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("rst_ready_during", {31'd0, ex_ready}, 32'd1);
    tick(); tick();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_err", {31'd0, err_stray}, 32'd0);
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("rst_fwd_rd", {27'd0, fwd_rd}, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", {31'd0, ex_ready}, 32'd1);

    // Simple non-load retire
    ex_valid = 1'b1; ex_rd = 5'd5; ex_result = 32'h1234_5678;
    tick();
    ex_valid = 1'b0;
    chk("alu_we", {31'd0, we}, 32'd1);
    chk("alu_waddr", {27'd0, waddr}, 32'd5);
    chk("alu_wdata", wdata, 32'h1234_5678);
    chk("alu_fwd_valid", {31'd0, fwd_valid}, {31'd0, FWD_ON});
    chk("alu_fwd_data", fwd_data, FWD_ON ? 32'h1234_5678 : 32'd0);
    tick();
    chk("alu_we_drop", {31'd0, we}, 32'd0);

    // LB with two wait cycles
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b000; ex_addr_lo = 2'd3; ex_rd = 5'd7;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    chk("lb_wait_ready0", {31'd0, ex_ready}, 32'd0);
    chk("lb_wait_we0", {31'd0, we}, 32'd0);
    tick();
    chk("lb_wait_ready1", {31'd0, ex_ready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("lb_we", {31'd0, we}, 32'd1);
    chk("lb_waddr", {27'd0, waddr}, 32'd7);
    chk("lb_wdata", wdata, 32'hFFFF_FF80);
    chk("lb_ready_after", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("lb_we_drop", {31'd0, we}, 32'd0);

    // Alignment table, one-cycle memory latency
    foreach (lv[i]) begin
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = lv[i].f3; ex_addr_lo = lv[i].lo;
      ex_rd = 5'(10 + i);
      tick();
      ex_valid = 1'b0; ex_is_load = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = lv[i].raw;
      tick();
      mem_rvalid = 1'b0;
      chk($sformatf("align%0d_we", i), {31'd0, we}, 32'd1);
      chk($sformatf("align%0d_data", i), wdata, lv[i].exp_v);
      tick();
    end

    // Three back-to-back non-loads
    ex_valid = 1'b1; ex_is_load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      ex_rd = 5'(k); ex_result = 32'(k * 32'h11);
      tick();
      chk($sformatf("b2b%0d_ready", k), {31'd0, ex_ready}, 32'd1);
      chk($sformatf("b2b%0d_we", k), {31'd0, we}, 32'd1);
      chk($sformatf("b2b%0d_waddr", k), {27'd0, waddr}, 32'(k));
      chk($sformatf("b2b%0d_wdata", k), wdata, 32'(k * 32'h11));
    end
    ex_valid = 1'b0;
    tick();
    chk("b2b_we_drop", {31'd0, we}, 32'd0);

    // rd=0 non-load: no write, port holds last values
    ex_valid = 1'b1; ex_rd = 5'd0; ex_result = 32'hDEAD_BEEF;
    tick();
    ex_valid = 1'b0;
    chk("rd0_we", {31'd0, we}, 32'd0);
    chk("rd0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("rd0_waddr_hold", {27'd0, waddr}, 32'd3);
    chk("rd0_wdata_hold", wdata, 32'h33);
    tick();

    // rd=0 load still waits for memory
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_rd = 5'd0;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    tick();
    chk("ld_rd0_wait", {31'd0, ex_ready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    chk("ld_rd0_we", {31'd0, we}, 32'd0);
    chk("ld_rd0_ready", {31'd0, ex_ready}, 32'd1);
    chk("ld_rd0_no_stray", {31'd0, err_stray}, 32'd0);
    tick();

    // Stray memory data in IDLE
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("stray_err", {31'd0, err_stray}, 32'd1);
    chk("stray_we", {31'd0, we}, 32'd0);
    tick(); tick();
    chk("stray_sticky", {31'd0, err_stray}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stray_cleared", {31'd0, err_stray}, 32'd0);

    // Reset abandons a pending load; late data is stray
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_rd = 5'd9;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    chk("rstld_wait", {31'd0, ex_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstld_ready", {31'd0, ex_ready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_rvalid = 1'b0;
    chk("rstld_no_we", {31'd0, we}, 32'd0);
    chk("rstld_wdata", wdata, 32'd0);
    chk("rstld_err", {31'd0, err_stray}, 32'd1);
    chk("rstld_idle", {31'd0, ex_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
